// File: rtl/commit_trace_buffer.sv
// Commit trace buffer for the single-cycle MIPS core: captures retired-instruction
// records into a DEPTH-entry circular buffer and drains them through a show-ahead port.
module commit_trace_buffer #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int POST   = 8
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic                       Arm,
    input  logic                       Stop,
    input  logic [1:0]                 Mode,
    input  logic                       FilterWr,
    input  logic [ADDR_W-1:0]          TrigPC,
    input  logic                       CommitValid,
    input  logic [ADDR_W-1:0]          CommitPC,
    input  logic [31:0]                CommitInstr,
    input  logic                       CommitRegWr,
    input  logic [4:0]                 CommitRD,
    input  logic [DATA_W-1:0]          CommitWData,
    input  logic                       RdReady,
    output logic                       RdValid,
    output logic [ADDR_W-1:0]          RdPC,
    output logic [31:0]                RdInstr,
    output logic                       RdRegWr,
    output logic [4:0]                 RdRD,
    output logic [DATA_W-1:0]          RdWData,
    output logic [$clog2(DEPTH):0]     Count,
    output logic                       Full,
    output logic                       Empty,
    output logic                       Triggered,
    output logic                       Overflow,
    output logic [1:0]                 State
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_RUN    = 2'b01,
        S_POST   = 2'b10,
        S_FROZEN = 2'b11
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic [PW-1:0]   post_q, post_d;
    logic            triggered_q, overflow_q;

    logic [ADDR_W-1:0] pc_mem    [DEPTH];
    logic [31:0]       instr_mem [DEPTH];
    logic              regwr_mem [DEPTH];
    logic [4:0]        rd_mem    [DEPTH];
    logic [DATA_W-1:0] wdata_mem [DEPTH];

    logic full, empty, pop, filt_ok, cap, ring, trig_hit;
    logic do_wr, drop, overwrite, trig_set;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign pop      = !empty && RdReady;
    assign filt_ok  = !FilterWr || (CommitRegWr && (CommitRD != 5'd0));
    assign cap      = ((state_q == S_RUN) || (state_q == S_POST)) && CommitValid && filt_ok;
    // Trigger mode and the post-trigger window always behave as a ring.
    assign ring     = (state_q == S_POST) || (Mode != 2'b00);
    assign trig_hit = cap && (state_q == S_RUN) && (Mode == 2'b10) && (CommitPC == TrigPC);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        post_d    = post_q;
        do_wr     = 1'b0;
        drop      = 1'b0;
        overwrite = 1'b0;
        trig_set  = 1'b0;
        if (Arm) begin
            state_d = S_RUN;
            post_d  = '0;
        end else if (Stop) begin
            state_d = S_IDLE;
        end else begin
            if (cap) begin
                if (full && !pop && !ring) begin
                    drop = 1'b1;
                end else begin
                    do_wr     = 1'b1;
                    overwrite = full && !pop;
                end
            end
            if (trig_hit) begin
                trig_set = 1'b1;
                post_d   = PW'(POST);
                state_d  = (POST == 0) ? S_FROZEN : S_POST;
            end else if ((state_q == S_POST) && do_wr) begin
                post_d = post_q - PW'(1);
                if (post_q == PW'(1)) state_d = S_FROZEN;
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            post_q      <= '0;
            triggered_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else if (Arm) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            post_q      <= '0;
            triggered_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            post_q <= post_d;
            if (do_wr) wr_ptr_q <= wr_ptr_q + PW'(1);
            // An overwrite on a full ring discards the oldest entry.
            if (pop || overwrite) rd_ptr_q <= rd_ptr_q + PW'(1);
            if (do_wr && !pop && !full)  count_q <= count_q + CW'(1);
            else if (!do_wr && pop)      count_q <= count_q - CW'(1);
            if (drop || overwrite) overflow_q  <= 1'b1;
            if (trig_set)          triggered_q <= 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (do_wr) begin
            pc_mem[wr_ptr_q]    <= CommitPC;
            instr_mem[wr_ptr_q] <= CommitInstr;
            regwr_mem[wr_ptr_q] <= CommitRegWr;
            rd_mem[wr_ptr_q]    <= CommitRD;
            wdata_mem[wr_ptr_q] <= CommitWData;
        end
    end

    assign RdValid   = !empty;
    assign RdPC      = empty ? '0    : pc_mem[rd_ptr_q];
    assign RdInstr   = empty ? '0    : instr_mem[rd_ptr_q];
    assign RdRegWr   = empty ? 1'b0  : regwr_mem[rd_ptr_q];
    assign RdRD      = empty ? 5'd0  : rd_mem[rd_ptr_q];
    assign RdWData   = empty ? '0    : wdata_mem[rd_ptr_q];
    assign Count     = count_q;
    assign Full      = full;
    assign Empty     = empty;
    assign Triggered = triggered_q;
    assign Overflow  = overflow_q;
    assign State     = state_q;

endmodule
